// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared IO address map and switch debouncer defaults
// Contents:
//   IO_WORD_W                width of every IO data word
//   DEFAULT_DEBOUNCE_CYCLES  default settle time for the switch filter
//   IO_*_BASE                peripheral base addresses shared with the LSU address decoder
//   SW_DEBOUNCE_EN           1 when IO_SW_DEBOUNCE_EN is defined, else 0
// Macro: IO_SW_DEBOUNCE_EN enables the counter-based bounce filter by default.
package io_pkg;

    localparam int          IO_WORD_W               = 32;
    localparam int          DEFAULT_DEBOUNCE_CYCLES = 500000;

    localparam logic [31:0] IO_SW_BASE              = 32'h1001_0000;
    localparam logic [31:0] IO_LED_BASE             = 32'h1001_0010;
    localparam logic [31:0] IO_SEG_BASE             = 32'h1001_0020;
    localparam logic [31:0] IO_UART_BASE            = 32'h1001_0030;

`ifdef IO_SW_DEBOUNCE_EN
    localparam bit          SW_DEBOUNCE_EN          = 1'b1;
`else
    localparam bit          SW_DEBOUNCE_EN          = 1'b0;
`endif

endpackage

// File: rtl/io_sw_debouncer_debounce_bit.sv
// rtl/io_sw_debouncer_debounce_bit.sv - one-bit synchroniser plus optional bounce filter
// Ports:
//   clk     core clock
//   rst     asynchronous active-high reset
//   raw     asynchronous switch level
//   stable  conditioned level
//   update  high in the cycle before stable takes a new value
// With DEBOUNCE_EN = 0 no counter exists and stable is the synchroniser output.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit DEBOUNCE_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic update
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE_EN) begin : g_filter
            localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt;

            // cnt counts consecutive mismatching cycles already seen, so the
            // mismatch is accepted on its DEBOUNCE_CYCLES-th consecutive edge.
            assign update = (sync2 != stable) && (cnt == CNT_LAST);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stable <= 1'b0;
                    cnt    <= '0;
                end else if (sync2 == stable) begin
                    cnt    <= '0;
                end else if (cnt == CNT_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt    <= cnt + 1'b1;
                end
            end
        end else begin : g_pass
            // stable is the second synchroniser flop itself; it is about to
            // change whenever the first flop differs from it.
            assign stable = sync2;
            assign update = (sync1 != sync2);
        end
    endgenerate

endmodule

// File: rtl/io_sw_debouncer.sv
// rtl/io_sw_debouncer.sv - synchronise and debounce board switches into the LSU switch word
// Ports:
//   i_clk         core clock
//   i_reset       asynchronous active-high reset
//   i_sw_raw      raw switch/key levels, asynchronous to i_clk
//   o_io_sw       debounced, zero-extended switch word read at IO_SW_BASE
//   o_sw_changed  one-cycle pulse after any bit of o_io_sw updates
// Macro: IO_SW_DEBOUNCE_EN selects the counter filter as the default of DEBOUNCE_EN.
module io_sw_debouncer
    import io_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit DEBOUNCE_EN     = SW_DEBOUNCE_EN
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [WIDTH-1:0]     i_sw_raw,
    output logic [IO_WORD_W-1:0] o_io_sw,
    output logic                 o_sw_changed
);

    logic [WIDTH-1:0] stb;
    logic [WIDTH-1:0] upd;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .DEBOUNCE_EN     (DEBOUNCE_EN)
            ) u_bit (
                .clk    (i_clk),
                .rst    (i_reset),
                .raw    (i_sw_raw[i]),
                .stable (stb[i]),
                .update (upd[i])
            );
        end
    endgenerate

    assign o_io_sw = IO_WORD_W'(stb);

    // Registered on the same edge that loads stb, so the pulse and the new
    // word become visible together and concurrent bit updates merge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_sw_changed <= 1'b0;
        end else begin
            o_sw_changed <= |upd;
        end
    end

endmodule

// File: tb/tb_io_sw_debouncer.sv
// tb/tb_io_sw_debouncer.sv - scoreboard bench for io_sw_debouncer (filtered and pass-through builds)
module tb_io_sw_debouncer;

    localparam int W = 18;
    localparam int D = 4;

    typedef struct {
        logic [31:0] word;
        int          at;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         rst2;
    logic [W-1:0] raw;
    logic [W-1:0] raw2;
    logic [31:0]  sw;
    logic [31:0]  sw2;
    logic         ch;
    logic         ch2;

    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    io_sw_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .DEBOUNCE_EN(1'b1)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_sw_raw     (raw),
        .o_io_sw      (sw),
        .o_sw_changed (ch)
    );

    io_sw_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .DEBOUNCE_EN(1'b0)) dut_fast (
        .i_clk        (clk),
        .i_reset      (rst2),
        .i_sw_raw     (raw2),
        .o_io_sw      (sw2),
        .o_sw_changed (ch2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect1(input logic [31:0] word, input int edges);
        exp_t e;
        e.word = word;
        e.at   = cyc + edges;
        q1.push_back(e);
    endtask

    task automatic expect2(input logic [31:0] word, input int edges);
        exp_t e;
        e.word = word;
        e.at   = cyc + edges;
        q2.push_back(e);
    endtask

    // Monitors: every change pulse must match the next queued update.
    always @(negedge clk) begin
        exp_t e;
        if (ch === 1'b1) begin
            if (q1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: got word %h at cycle %0d, want no pulse", sw, cyc);
            end else begin
                e = q1.pop_front();
                check("pulse_word", sw, e.word);
                check("pulse_cycle", cyc, e.at);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ch2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL fast_unexpected_pulse: got word %h at cycle %0d, want no pulse", sw2, cyc);
            end else begin
                e = q2.pop_front();
                check("fast_pulse_word", sw2, e.word);
                check("fast_pulse_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        raw  = '0;
        raw2 = '0;

        // Reset state
        step(3);
        check("reset_sw", sw, 32'h0);
        check("reset_changed", {31'b0, ch}, 32'h0);
        check("fast_reset_sw", sw2, 32'h0);
        rst  = 1'b0;
        rst2 = 1'b0;
        step(1);

        // Reset mid-count: all bits high, reset pulsed after 3 cycles
        raw = '1;
        step(3);
        #2 rst = 1'b1;
        #1 check("midcount_async_clear", sw, 32'h0);
        rst = 1'b0;
        expect1(32'h0003_FFFF, 6);
        step(5);
        check("midcount_e4_not_yet", sw, 32'h0);
        step(1);
        check("midcount_e5_word", sw, 32'h0003_FFFF);
        raw = '0;
        expect1(32'h0, 6);
        step(6);
        check("all_low_word", sw, 32'h0);

        // Clean step on bit 0
        raw[0] = 1'b1;
        expect1(32'h1, 6);
        step(5);
        check("step_e4_not_yet", sw, 32'h0);
        step(1);
        check("step_e5_word", sw, 32'h1);
        check("step_e5_pulse", {31'b0, ch}, 32'h1);
        step(1);
        check("step_pulse_one_cycle", {31'b0, ch}, 32'h0);

        // Bounce on bit 3: 1,0,1,0,1 then held
        raw[3] = 1'b1; step(1);
        raw[3] = 1'b0; step(1);
        raw[3] = 1'b1; step(1);
        raw[3] = 1'b0; step(1);
        raw[3] = 1'b1;
        expect1(32'h9, 6);
        step(5);
        check("bounce_e4_not_yet", sw, 32'h1);
        step(1);
        check("bounce_e5_word", sw, 32'h9);

        // Short glitch on bit 17: three cycles high is one short of acceptance
        raw[17] = 1'b1;
        step(3);
        raw[17] = 1'b0;
        step(8);
        check("glitch_word", sw, 32'h9);
        check("glitch_no_pulse", {31'b0, ch}, 32'h0);

        // Bits 0 and 3 fall together: one merged pulse
        raw = '0;
        expect1(32'h0, 6);
        step(7);

        // Independent bits 1 and 2
        raw[1] = 1'b1;
        expect1(32'h2, 6);
        step(2);
        raw[2] = 1'b1;
        expect1(32'h6, 6);
        step(4);
        check("indep_first_word", sw, 32'h2);
        step(1);
        check("indep_gap_no_pulse", {31'b0, ch}, 32'h0);
        step(1);
        check("indep_second_word", sw, 32'h6);

        // Asynchronous reset of a settled word; held inputs are a fresh change
        step(2);
        #2 rst = 1'b1;
        #1 check("settled_async_clear", sw, 32'h0);
        rst = 1'b0;
        expect1(32'h6, 6);
        step(7);
        check("upper_bits_zero", {14'b0, sw[31:18]}, 32'h0);

        // Pass-through build: bit 5 visible at E1
        raw2[5] = 1'b1;
        expect2(32'h20, 2);
        step(1);
        check("fast_e0_not_yet", sw2, 32'h0);
        step(1);
        check("fast_e1_word", sw2, 32'h20);
        check("fast_e1_pulse", {31'b0, ch2}, 32'h1);
        raw2 = '0;
        expect2(32'h0, 2);
        step(3);
        check("fast_fall_word", sw2, 32'h0);

        step(2);
        check("q1_drained", q1.size(), 32'h0);
        check("q2_drained", q2.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/io_sw_debouncer.md
# io_sw_debouncer

Input conditioning stage directly upstream of the load/store unit's switch read path. It takes raw, asynchronous board switch and key levels, synchronises every bit into the core clock domain, and filters contact bounce. It presents a stable 32-bit word that the LSU returns unchanged for loads from the switch region at 0x1001_0000.

## Interface
Parameters:
- WIDTH, 32: number of input bits conditioned; bits above WIDTH in o_io_sw are driven 0; legal range 1..32.
- DEBOUNCE_CYCLES, 500000: consecutive clock cycles a new level must persist before being accepted; must be ≥1.

Ports:
- i_clk  input  1  core clock; all state updates on rising edge.
- i_reset  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- i_sw_raw  input  WIDTH  raw switch/key levels, asynchronous to i_clk.
- o_io_sw  output  32  debounced switch word; connects to the LSU i_io_sw.
- o_sw_changed  output  1  one-cycle pulse when any bit of o_io_sw updates.

## Operation
- Per bit i: 2-flop synchroniser sync1[i] → sync2[i], stable register stb[i], counter cnt[i] of width $clog2(DEBOUNCE_CYCLES+1).
- Each rising edge, with IO_SW_DEBOUNCE_EN defined:
  - sync2[i] == stb[i]: cnt[i] ← 0.
  - sync2[i] != stb[i] and cnt[i] == DEBOUNCE_CYCLES-1: stb[i] ← sync2[i], cnt[i] ← 0.
  - Otherwise: cnt[i] ← cnt[i]+1.
- A mismatch interrupted by even one matching cycle restarts the count from 0. Glitches shorter than DEBOUNCE_CYCLES never reach o_io_sw.
- Counter never wraps. The maximum value held is DEBOUNCE_CYCLES-1.
- o_io_sw = {(32-WIDTH)'b0, stb}.
- o_sw_changed is registered. It is 1 in the cycle after any stb bit updates and 0 otherwise. Simultaneous updates on several bits produce one pulse.
- Bits are fully independent; simultaneous changes on several bits each follow their own counter.

## Timing
- Reset values: sync1, sync2, stb and cnt all 0; o_io_sw = 0; o_sw_changed = 0.
- Reset assertion clears all state immediately, without waiting for a clock, including mid-count.
- After reset release, any input held high is a fresh change and needs the full latency below.
- Latency with debounce: count edge E0 as the first rising edge that samples the new raw level into sync1. o_io_sw updates at edge E(DEBOUNCE_CYCLES+1), i.e. DEBOUNCE_CYCLES+2 edges inclusive. This holds only if the level is held throughout.
- o_sw_changed is high for the cycle following that edge.
- Latency without debounce: o_io_sw follows sync2, so it updates at edge E1.
- No handshake: the output is a level, readable by the LSU in any cycle. A load in the update cycle returns either the old or the new word, never a mix within one bit.

## Configuration
- IO_SW_DEBOUNCE_EN defined: counters and filter as above.
- IO_SW_DEBOUNCE_EN undefined: counters are not instantiated. stb[i] ← sync2[i] every edge, and o_sw_changed pulses when stb changes. Intended for fast simulation and short test programs; the synchroniser always remains.

## Structure
- Shared package io_pkg holds:
  - IO_SW_BASE = 32'h1001_0000.
  - IO_WORD_W = 32.
  - DEFAULT_DEBOUNCE_CYCLES = 500000.
  - Peripheral base addresses shared with the LSU address decoder.
- Sub-module debounce_bit: one synchroniser, counter and stable flop, with a per-bit update strobe. Instantiated WIDTH times in a generate loop.
- The top level does zero-extension and the OR-reduce that drives o_sw_changed.

## Test plan
Bench uses WIDTH=18, DEBOUNCE_CYCLES=4, IO_SW_DEBOUNCE_EN defined.
- **Reset mid-count:** i_sw_raw=18'h3FFFF, then i_reset pulsed high after 3 cycles. Required: o_io_sw=0 immediately. After release, 6 edges are required before o_io_sw=32'h0003FFFF.
- **Clean step:** bit 0 raised and held. Required: o_io_sw[0]=1 exactly at edge E5; o_sw_changed=1 for exactly one cycle after E5.
- **Bounce:** bit 3 toggled 1,0,1,0,1 on consecutive cycles, then held at 1. Required: no update before 6 edges after the final rise; exactly one o_sw_changed pulse.
- **Short glitch:** bit 17 high for 3 cycles, then low. Required: o_io_sw stays 0 and o_sw_changed stays 0.
- **Independent bits:** bit 1 rises at cycle 0 and bit 2 at cycle 2. Required: o_io_sw=32'h2 then 32'h6, with two separate pulses. Upper bits [31:18] stay 0 throughout.
- **Macro undefined:** bit 5 rises. Required: o_io_sw[5]=1 at edge E1.
